// File: rtl/stage_mem.sv
// ---------------------------------------------------------------------------
// stage_mem : MEM pipeline stage with a variable-latency data-memory port.
//
// Loads (opcode 4'b1000) and stores (opcode 4'b1001) are presented to data
// memory combinationally. The request is held until memReady=1. While the
// access is outstanding, stall freezes EX/MEM and everything upstream, and
// bubbles are pushed into the WB register. Non-memory instructions pass
// through in one cycle. An 8-bit saturating wait counter raises a sticky
// memTimeout flag when a single access has waited 256 WAIT cycles. The access
// keeps waiting after that.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   validIn         : EX/MEM entry valid
//   instrIn         : instruction (opcode in [15:12])
//   exResult        : ALU result / memory address / PC+2
//   storeData       : store write data
//   rdIn            : destination register
//   PCjumpIn        : jump target, passed to WB
//   memRdata        : memory read data, valid with memReady
//   memReady        : memory finishes the current access this cycle
//   memAddr/memWdata/memRe/memWe : data-memory request (combinational)
//   stall           : hold EX/MEM and upstream (combinational)
//   memResult/instr/PCjump/rd/validOut : registered WB entry
//   memTimeout      : sticky timeout error flag (registered)
// ---------------------------------------------------------------------------
module stage_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        validIn,
  input  logic [15:0] instrIn,
  input  logic [15:0] exResult,
  input  logic [15:0] storeData,
  input  logic [3:0]  rdIn,
  input  logic [15:0] PCjumpIn,
  input  logic [15:0] memRdata,
  input  logic        memReady,
  output logic [15:0] memAddr,
  output logic [15:0] memWdata,
  output logic        memRe,
  output logic        memWe,
  output logic        stall,
  output logic [15:0] memResult,
  output logic [15:0] instr,
  output logic [15:0] PCjump,
  output logic [3:0]  rd,
  output logic        validOut,
  output logic        memTimeout
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;

  logic [15:0] mem_result_q, mem_result_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_jump_q, pc_jump_d;
  logic [3:0]  rd_q, rd_d;
  logic        valid_q, valid_d;

  logic        is_lw_s, is_sw_s, is_mem_s;
  logic        req_re_s, req_we_s, req_any_s, stall_s;

  assign is_lw_s   = validIn & (instrIn[15:12] == 4'b1000);
  assign is_sw_s   = validIn & (instrIn[15:12] == 4'b1001);
  assign is_mem_s  = is_lw_s | is_sw_s;

  // The request is a pure function of the held EX/MEM inputs. This holds in
  // IDLE and in WAIT, because upstream keeps them stable while stalled.
  // Reset masks the request so that an abandoned access goes off the bus at once.
  assign req_re_s  = ~rst & is_lw_s;
  assign req_we_s  = ~rst & is_sw_s;
  assign req_any_s = req_re_s | req_we_s;
  assign stall_s   = req_any_s & ~memReady;

  assign memRe     = req_re_s;
  assign memWe     = req_we_s;
  assign memAddr   = req_any_s ? exResult  : 16'h0000;
  assign memWdata  = req_any_s ? storeData : 16'h0000;
  assign stall     = stall_s;

  assign memResult  = mem_result_q;
  assign instr      = instr_q;
  assign PCjump     = pc_jump_q;
  assign rd         = rd_q;
  assign validOut   = valid_q;
  assign memTimeout = timeout_q;

  // Access FSM next state, wait counter and sticky timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (is_mem_s & ~memReady) begin
          state_d    = WAIT;
          wait_cnt_d = 8'h00;
        end else begin
          state_d    = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'h01;
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
        if (memReady) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          // The counter saturates, so the flag is set on the 256th WAIT cycle
          // and on every later cycle of the same access.
          if (wait_cnt_q == 8'hFF) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // WB register next value. A stalled cycle or an invalid entry loads a
  // bubble; rd=0 suppresses the register-file write downstream.
  always_comb begin
    mem_result_d = 16'h0000;
    instr_d      = 16'h0000;
    pc_jump_d    = 16'h0000;
    rd_d         = 4'h0;
    valid_d      = 1'b0;
    if (stall_s | ~validIn) begin
      mem_result_d = 16'h0000;
      instr_d      = 16'h0000;
      pc_jump_d    = 16'h0000;
      rd_d         = 4'h0;
      valid_d      = 1'b0;
    end else begin
      mem_result_d = is_lw_s ? memRdata : exResult;
      instr_d      = instrIn;
      pc_jump_d    = PCjumpIn;
      rd_d         = rdIn;
      valid_d      = 1'b1;
    end
  end

  // FSM state, counter and timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // WB pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_result_q <= 16'h0000;
      instr_q      <= 16'h0000;
      pc_jump_q    <= 16'h0000;
      rd_q         <= 4'h0;
      valid_q      <= 1'b0;
    end else begin
      mem_result_q <= mem_result_d;
      instr_q      <= instr_d;
      pc_jump_q    <= pc_jump_d;
      rd_q         <= rd_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// ---------------------------------------------------------------------------
// tb_stage_mem : bench for stage_mem.
// A behavioural model runs in the negedge compare process. Each cycle it
// works out the expected request, stall and next WB entry from the opcode
// rules. It also keeps a count of consecutive stalled cycles for the current
// access; the timeout flag must rise once that count exceeds 256 (1 IDLE cycle
// + 256 WAIT cycles). Directed sequences add literal expectations, and a
// randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        rst, validIn, memReady;
  logic [15:0] instrIn, exResult, storeData, PCjumpIn, memRdata;
  logic [3:0]  rdIn;
  logic [15:0] memAddr, memWdata, memResult, instr, PCjump;
  logic        memRe, memWe, stall, validOut, memTimeout;
  logic [3:0]  rd;

  int checks = 0;
  int errors = 0;

  // Model state and the expected WB register after the coming edge.
  bit          have_exp = 1'b0;
  int          m_run = 0;
  bit          m_to = 1'b0;
  bit          cyc_stall = 1'b0;
  logic [15:0] x_res, x_instr, x_pc;
  logic [3:0]  x_rd;
  logic        x_valid, x_to;

  stage_mem dut (
    .clk(clk), .rst(rst), .validIn(validIn), .instrIn(instrIn),
    .exResult(exResult), .storeData(storeData), .rdIn(rdIn),
    .PCjumpIn(PCjumpIn), .memRdata(memRdata), .memReady(memReady),
    .memAddr(memAddr), .memWdata(memWdata), .memRe(memRe), .memWe(memWe),
    .stall(stall), .memResult(memResult), .instr(instr), .PCjump(PCjump),
    .rd(rd), .validOut(validOut), .memTimeout(memTimeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic v, input logic [15:0] ins, input logic [15:0] exr,
                       input logic [15:0] sd, input logic [3:0] r, input logic [15:0] pcj,
                       input logic [15:0] rdata, input logic rdy);
    validIn = v; instrIn = ins; exResult = exr; storeData = sd;
    rdIn = r; PCjumpIn = pcj; memRdata = rdata; memReady = rdy;
  endtask

  // Compare process: check the DUT against the model, then advance the model.
  always @(negedge clk) begin
    bit lw, sw, e_re, e_we, e_stall;
    if (have_exp) begin
      chk("memResult", memResult, x_res);
      chk("instr", instr, x_instr);
      chk("PCjump", PCjump, x_pc);
      chk("rd", {12'h000, rd}, {12'h000, x_rd});
      chk("validOut", {15'h0000, validOut}, {15'h0000, x_valid});
      chk("memTimeout", {15'h0000, memTimeout}, {15'h0000, x_to});
    end
    lw = validIn && (instrIn[15:12] == 4'h8);
    sw = validIn && (instrIn[15:12] == 4'h9);
    e_re = !rst && lw;
    e_we = !rst && sw;
    e_stall = (e_re || e_we) && !memReady;
    chk("memRe", {15'h0000, memRe}, {15'h0000, e_re});
    chk("memWe", {15'h0000, memWe}, {15'h0000, e_we});
    chk("stall", {15'h0000, stall}, {15'h0000, e_stall});
    if (rst) begin
      chk("memAddr_rst", memAddr, 16'h0000);
      chk("memWdata_rst", memWdata, 16'h0000);
    end else if (lw || sw) begin
      chk("memAddr", memAddr, exResult);
      chk("memWdata", memWdata, storeData);
    end
    cyc_stall = e_stall;
    if (rst || e_stall || !validIn) begin
      x_res = 16'h0000; x_instr = 16'h0000; x_pc = 16'h0000; x_rd = 4'h0; x_valid = 1'b0;
    end else begin
      x_res = lw ? memRdata : exResult;
      x_instr = instrIn; x_pc = PCjumpIn; x_rd = rdIn; x_valid = 1'b1;
    end
    if (rst) begin
      m_run = 0; m_to = 1'b0;
    end else if (e_stall) begin
      m_run++;
      if (m_run >= 257) m_to = 1'b1;
    end else begin
      m_run = 0;
    end
    x_to = m_to;
    have_exp = 1'b1;
  end

  initial begin
    rst = 1'b1;
    setin(1'b0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0000, 1'b0);
    step(); step();
    chk("reset_validOut", {15'h0000, validOut}, 16'h0000);
    chk("reset_timeout", {15'h0000, memTimeout}, 16'h0000);
    rst = 1'b0;

    // Non-memory ADD passes in one cycle.
    setin(1'b1, 16'h0123, 16'h00AA, 16'h5555, 4'h1, 16'h0300, 16'hDEAD, 1'b0);
    #1;
    chk("add_stall", {15'h0000, stall}, 16'h0000);
    chk("add_req", {14'h0000, memRe, memWe}, 16'h0000);
    step();
    chk("add_res", memResult, 16'h00AA);
    chk("add_instr", instr, 16'h0123);
    chk("add_rd", {12'h000, rd}, 16'h0001);
    chk("add_valid", {15'h0000, validOut}, 16'h0001);

    // Zero-wait load.
    setin(1'b1, 16'h8210, 16'h0040, 16'h0000, 4'h2, 16'h0000, 16'hBEEF, 1'b1);
    #1;
    chk("lw0_re", {15'h0000, memRe}, 16'h0001);
    chk("lw0_addr", memAddr, 16'h0040);
    chk("lw0_stall", {15'h0000, stall}, 16'h0000);
    step();
    chk("lw0_res", memResult, 16'hBEEF);

    // Store with three wait cycles.
    setin(1'b1, 16'h9345, 16'h0010, 16'h1234, 4'h0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sw_we_wait", {15'h0000, memWe}, 16'h0001);
      chk("sw_stall", {15'h0000, stall}, 16'h0001);
      chk("sw_addr", memAddr, 16'h0010);
      chk("sw_wdata", memWdata, 16'h1234);
      step();
      chk("sw_bubble", instr, 16'h0000);
    end
    memReady = 1'b1;
    #1;
    chk("sw_we_last", {15'h0000, memWe}, 16'h0001);
    chk("sw_stall_last", {15'h0000, stall}, 16'h0000);
    step();
    chk("sw_instr", instr, 16'h9345);
    validIn = 1'b0;
    #1;
    chk("sw_we_after", {15'h0000, memWe}, 16'h0000);
    step();

    // Long load: timeout after 1 IDLE + 256 WAIT cycles, then completes.
    setin(1'b1, 16'h8500, 16'h0080, 16'h0000, 4'h5, 16'h0000, 16'h0000, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 256) chk("to_not_yet", {15'h0000, memTimeout}, 16'h0000);
      if (i == 257) chk("to_set", {15'h0000, memTimeout}, 16'h0001);
    end
    chk("to_stall", {15'h0000, stall}, 16'h0001);
    memReady = 1'b1; memRdata = 16'h1357;
    #1;
    chk("to_done_stall", {15'h0000, stall}, 16'h0000);
    step();
    chk("to_res", memResult, 16'h1357);
    chk("to_sticky", {15'h0000, memTimeout}, 16'h0001);

    // Reset in WAIT abandons the access.
    setin(1'b1, 16'h8600, 16'h0090, 16'h0000, 4'h6, 16'h0000, 16'h0000, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("rst_re", {15'h0000, memRe}, 16'h0000);
    chk("rst_addr", memAddr, 16'h0000);
    step();
    chk("rst_valid", {15'h0000, validOut}, 16'h0000);
    chk("rst_rd", {12'h000, rd}, 16'h0000);
    chk("rst_to", {15'h0000, memTimeout}, 16'h0000);
    rst = 1'b0; validIn = 1'b0;
    #1;
    chk("post_rst_req", {14'h0000, memRe, memWe}, 16'h0000);
    step();

    // Back-to-back zero-wait loads.
    setin(1'b1, 16'h8700, 16'h0100, 16'h0000, 4'h3, 16'h0000, 16'h1111, 1'b1);
    step();
    chk("b2b_res0", memResult, 16'h1111);
    setin(1'b1, 16'h8800, 16'h0102, 16'h0000, 4'h4, 16'h0000, 16'h2222, 1'b1);
    step();
    chk("b2b_res1", memResult, 16'h2222);
    chk("b2b_valid1", {15'h0000, validOut}, 16'h0001);
    chk("b2b_rd1", {12'h000, rd}, 16'h0004);

    // Randomized traffic; inputs change only when the last cycle did not stall.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      memReady = ($urandom_range(0, 3) != 0);
      memRdata = 16'($urandom);
      if (!cyc_stall) begin
        logic [3:0] op;
        case ($urandom_range(0, 3))
          0: op = 4'h8;
          1: op = 4'h9;
          default: op = 4'($urandom);
        endcase
        validIn = ($urandom_range(0, 4) != 0);
        instrIn = {op, 12'($urandom)};
        exResult = 16'($urandom);
        storeData = 16'($urandom);
        rdIn = 4'($urandom);
        PCjumpIn = 16'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_MEM

Interface
- REQ-001: The block SHALL have these ports:
  - clk  in  1  -- single clock; all state updates on its rising edge.
  - rst  in  1  -- reset, synchronous, active-high.
  - validIn  in  1  -- EX/MEM entry valid.
  - instrIn  in  16  -- instruction from EX/MEM.
  - exResult  in  16  -- ALU result, load/store address, or PC+2 for JAL.
  - storeData  in  16  -- SW write data.
  - rdIn  in  4  -- destination register.
  - PCjumpIn  in  16  -- jump target, passed through.
  - memRdata  in  16  -- data memory read data, valid when memReady=1.
  - memReady  in  1  -- data memory completes the current access this cycle.
  - memAddr  out  16  -- data memory address.
  - memWdata  out  16  -- data memory write data.
  - memRe  out  1  -- read request.
  - memWe  out  1  -- write request.
  - stall  out  1  -- hold EX/MEM and all upstream stages.
  - memResult  out  16  -- registered to WB.
  - instr  out  16  -- registered to WB.
  - PCjump  out  16  -- registered to WB.
  - rd  out  4  -- registered to WB.
  - validOut  out  1  -- registered; WB entry valid.
  - memTimeout  out  1  -- sticky error flag.

Function
- REQ-002: LW SHALL be instrIn[15:12]=4'b1000; SW SHALL be instrIn[15:12]=4'b1001; isMem = validIn & (LW|SW).
- REQ-003: The FSM SHALL have exactly two states, IDLE and WAIT.
- REQ-004: IDLE with isMem=1 and rst=0 SHALL drive memRe=LW, memWe=SW, memAddr=exResult, memWdata=storeData combinationally in that same cycle.
- REQ-005: WAIT SHALL keep driving the same request signals from the same inputs; upstream holds the inputs stable while stall=1.
- REQ-006: stall SHALL equal (memRe|memWe) & ~memReady, evaluated combinationally.
- REQ-007: Transitions:
  - IDLE -> WAIT when isMem & ~memReady.
  - IDLE stays IDLE when isMem & memReady (zero-wait access).
  - WAIT -> IDLE when memReady=1.
  - WAIT stays WAIT otherwise.
- REQ-008: Each access SHALL be presented to memory until exactly the cycle memReady=1 and SHALL NOT be reissued after that cycle.
- REQ-009: The WB register SHALL load each cycle stall=0:
  - memResult = LW ? memRdata : exResult
  - instr = instrIn
  - rd = rdIn
  - PCjump = PCjumpIn
  - validOut = validIn
- REQ-010: While stall=1, the WB register SHALL load a bubble: memResult=16'h0000, instr=16'h0000, rd=4'h0, PCjump=16'h0000, validOut=0.
- REQ-011: A bubble SHALL cause no register write downstream, because rd=0 suppresses the write.
- REQ-012: validIn=0 with stall=0 SHALL load the bubble of REQ-010 regardless of instrIn.
- REQ-013: Non-memory instructions, including JAL, SHALL pass in one cycle with no memory request, memRe=memWe=0.
- REQ-014: An 8-bit waitCnt SHALL clear on every IDLE->WAIT transition and increment each cycle in WAIT.
- REQ-015: waitCnt SHALL saturate at 8'hFF.
- REQ-016: memTimeout SHALL set on the clock edge where waitCnt=8'hFF while in WAIT with memReady=0.
- REQ-017: memTimeout SHALL clear only on reset; the access continues to wait regardless of memTimeout.
- REQ-018: Load-result latency SHALL be exactly one clock edge after the cycle memReady=1.

Reset
- REQ-019: On a clock edge with rst=1:
  - state SHALL go to IDLE.
  - waitCnt SHALL clear to 0 and memTimeout to 0.
  - The WB register SHALL load the bubble of REQ-010.
- REQ-020: While rst=1, memRe, memWe and stall SHALL be 0 combinationally, and memAddr and memWdata SHALL be 16'h0000.
- REQ-021: Reset asserted in WAIT SHALL abandon the access; after reset deassertion, the first cycle SHALL issue nothing unless a new isMem is presented.

Verification
- REQ-022: Non-memory ADD, instrIn=16'h0123, exResult=16'h00AA, rdIn=1, validIn=1 -> next edge: memResult=16'h00AA, instr=16'h0123, rd=1, validOut=1; stall=0 throughout.
- REQ-023: LW, exResult=16'h0040, memReady=1 same cycle, memRdata=16'hBEEF -> memRe=1, memAddr=16'h0040, stall=0; next edge: memResult=16'hBEEF.
- REQ-024: SW, exResult=16'h0010, storeData=16'h1234, memReady low 3 cycles then high -> memWe=1 for 4 cycles with stable address and data; stall=1 for 3 cycles; 3 bubbles reach WB, then instr=SW; memWe=0 afterwards.
- REQ-025: LW with memReady held low 300 cycles -> memTimeout rises after 256 WAIT cycles and stays high; stall stays 1; memReady=1 completes the load normally.
- REQ-026: rst=1 during WAIT of an LW -> memRe=0 immediately; after the edge: state IDLE, validOut=0, rd=0, memTimeout=0; no request after rst drops with validIn=0.
- REQ-027: Back-to-back LW, LW, both zero-wait -> two consecutive WB entries with the correct memRdata values and no bubble between them.
